// File: rtl/alu_exec_ctrl.sv
// EX-stage ALU control decode plus an iterative mult/div sequencer that owns HI/LO.
// Define ALU_EXEC_DIV_EN to build the restoring divider for div/divu.
module alu_exec_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       aluOp,
  input  logic [5:0]       funct,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic [2:0]       aluControl,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e state_q, state_d;

  logic             is_rtype;
  logic             is_mul_op;
  logic             is_div_op;
  logic             is_muldiv;
  logic             is_hilo_rd;
  logic             is_signed_op;
  logic             accept;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_fix;

`ifdef ALU_EXEC_DIV_EN
  logic             is_div_q, is_div_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH:0]   div_trial;
  logic             div_take;
  logic [WIDTH-1:0] div_rem;
`endif

  // ALU select decode
  always_comb begin
    aluControl = 3'b010;
    if (aluOp == 2'b01) begin
      aluControl = 3'b110;
    end else if (aluOp == 2'b10) begin
      case (funct)
        6'b100010: aluControl = 3'b110;
        6'b100100: aluControl = 3'b000;
        6'b100101: aluControl = 3'b001;
        6'b101010: aluControl = 3'b111;
        default:   aluControl = 3'b010;
      endcase
    end
  end

  assign is_rtype     = (aluOp == 2'b10);
  assign is_mul_op    = is_rtype && (funct[5:1] == 5'b01100);
`ifdef ALU_EXEC_DIV_EN
  assign is_div_op    = is_rtype && (funct[5:1] == 5'b01101);
`else
  assign is_div_op    = 1'b0;
`endif
  assign is_muldiv    = is_mul_op | is_div_op;
  assign is_hilo_rd   = is_rtype && ((funct == 6'b010000) || (funct == 6'b010010));
  // Even funct codes (mult/div) are the signed variants.
  assign is_signed_op = ~funct[0];

  assign mag_a = (is_signed_op && opA[WIDTH-1]) ? -opA : opA;
  assign mag_b = (is_signed_op && opB[WIDTH-1]) ? -opB : opB;

  assign accept = start & is_muldiv & (state_q == StIdle);
  assign busy   = (state_q != StIdle);
  assign stall  = busy & start & (is_muldiv | is_hilo_rd);
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (cnt_q == WIDTH'(WIDTH - 1)) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    // Shift-add: add multiplicand when the current multiplier bit is set, then shift right.
    mul_sum  = {1'b0, acc_hi_q} + {1'b0, opnd_q & {WIDTH{acc_lo_q[0]}}};
    prod_fix = neg_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};

`ifdef ALU_EXEC_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    a_raw_d   = a_raw_q;
    // Restoring step; a taken difference is below the divisor, so WIDTH bits hold it.
    div_trial = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_take  = (div_trial >= {1'b0, opnd_q});
    div_rem   = div_take ? (div_trial[WIDTH-1:0] - opnd_q) : div_trial[WIDTH-1:0];
`endif

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d    = '0;
          acc_hi_d = '0;
          acc_lo_d = mag_b;
          opnd_d   = mag_a;
          neg_d    = is_signed_op & (opA[WIDTH-1] ^ opB[WIDTH-1]);
`ifdef ALU_EXEC_DIV_EN
          is_div_d  = is_div_op;
          neg_rem_d = is_signed_op & opA[WIDTH-1];
          a_raw_d   = opA;
          if (is_div_op) begin
            acc_lo_d = mag_a;
            opnd_d   = mag_b;
          end
`endif
        end
      end
      StRun: begin
        cnt_d    = cnt_q + 1'b1;
        acc_hi_d = mul_sum[WIDTH:1];
        acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
`ifdef ALU_EXEC_DIV_EN
        if (is_div_q) begin
          acc_hi_d = div_rem;
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_take};
        end
`endif
      end
      StFix: begin
        cnt_d  = '0;
        done_d = 1'b1;
        hi_d   = prod_fix[2*WIDTH-1:WIDTH];
        lo_d   = prod_fix[WIDTH-1:0];
`ifdef ALU_EXEC_DIV_EN
        if (is_div_q) begin
          if (opnd_q == '0) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
            lo_d = neg_q ? -acc_lo_q : acc_lo_q;
          end
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

`ifdef ALU_EXEC_DIV_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      a_raw_q   <= '0;
    end else begin
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      a_raw_q   <= a_raw_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl (WIDTH=32); div checks follow ALU_EXEC_DIV_EN.
module tb_alu_exec_ctrl;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [1:0]   aluOp = 2'b00;
  logic [5:0]   funct = 6'b000000;
  logic         start = 1'b0;
  logic [W-1:0] opA = '0;
  logic [W-1:0] opB = '0;
  logic [2:0]   aluControl;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int failures = 0;

  alu_exec_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluOp      (aluOp),
    .funct      (funct),
    .start      (start),
    .opA        (opA),
    .opB        (opB),
    .aluControl (aluControl),
    .busy       (busy),
    .stall      (stall),
    .done       (done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  // Issue one R-type mult/div and wait (bounded) for done; lat = -1 on timeout.
  task automatic do_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] rh, output logic [W-1:0] rl,
                       output int lat, output int bcnt);
    @(negedge clk);
    aluOp = 2'b10; funct = f; opA = a; opB = b; start = 1'b1;
    lat = -1; bcnt = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bcnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    rh = hi; rl = lo;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (hi !== '0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== '0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_decode();
    logic [1:0] t_op [10];
    logic [5:0] t_fn [10];
    logic [2:0] t_ex [10];
    t_op = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    t_fn = '{6'b100010, 6'b100000, 6'b101010, 6'b100000, 6'b100010,
             6'b100100, 6'b100101, 6'b101010, 6'b111111, 6'b011000};
    t_ex = '{3'b010, 3'b110, 3'b010, 3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010, 3'b010};
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      aluOp = t_op[i]; funct = t_fn[i];
      #1;
      checks++;
      if (aluControl !== t_ex[i]) begin
        failures++;
        $display("FAIL decode[%0d] aluOp=%b funct=%b got=%b exp=%b", i, t_op[i], t_fn[i],
                 aluControl, t_ex[i]);
      end
    end
  endtask

  task automatic test_mult();
    logic [5:0]   v_f  [6];
    logic [W-1:0] v_a  [6];
    logic [W-1:0] v_b  [6];
    logic [W-1:0] v_eh [6];
    logic [W-1:0] v_el [6];
    logic [W-1:0] rh, rl;
    int lat, bcnt;
    v_f  = '{6'b011000, 6'b011001, 6'b011000, 6'b011000, 6'b011001, 6'b011000};
    v_a  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
             32'h8000_0000};
    v_b  = '{32'd7, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd1};
    v_eh = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h4000_0000, 32'h0, 32'h1, 32'hFFFF_FFFF};
    v_el = '{32'hFFFF_FFEB, 32'h0000_0001, 32'h0, 32'h8000_0000, 32'h0, 32'h8000_0000};
    for (int i = 0; i < 6; i++) begin
      do_op(v_f[i], v_a[i], v_b[i], rh, rl, lat, bcnt);
      checks++; if (lat != 34) begin failures++; $display("FAIL mult[%0d]_latency got=%0d exp=34", i, lat); end
      checks++; if (rh !== v_eh[i]) begin failures++; $display("FAIL mult[%0d]_hi got=%h exp=%h", i, rh, v_eh[i]); end
      checks++; if (rl !== v_el[i]) begin failures++; $display("FAIL mult[%0d]_lo got=%h exp=%h", i, rl, v_el[i]); end
      if (i == 0) begin
        checks++; if (bcnt != 33) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=33", bcnt); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done); end
      end
    end
  endtask

  task automatic test_stall();
    int nstall, done_at;
    @(negedge clk);
    aluOp = 2'b10; funct = 6'b011000; opA = 32'd6; opB = 32'd7; start = 1'b1;
    @(negedge clk);
    aluOp = 2'b00; funct = 6'b100000; opA = 32'd100; opB = 32'd100;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_add got=%b exp=0", stall); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL stall_busy got=%b exp=1", busy); end
    @(negedge clk);
    aluOp = 2'b10; funct = 6'b011000;
    #1;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_mult_busy got=%b exp=1", stall); end
    nstall = 1; done_at = -1;
    @(negedge clk);
    funct = 6'b010010;
    #1;
    for (int k = 3; k <= 100; k++) begin
      if (stall) nstall++;
      if (done) begin
        done_at = k;
        break;
      end
      @(negedge clk);
      #1;
    end
    start = 1'b0;
    checks++; if (done_at != 34) begin failures++; $display("FAIL stall_done_at got=%0d exp=34", done_at); end
    checks++; if (nstall != 32) begin failures++; $display("FAIL stall_cycles got=%0d exp=32", nstall); end
    checks++; if (lo !== 32'd42) begin failures++; $display("FAIL stall_lo got=%h exp=%h", lo, 32'd42); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL stall_hi got=%h exp=0", hi); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stall_no_restart got=%b exp=0", busy); end
  endtask

`ifdef ALU_EXEC_DIV_EN
  task automatic test_div();
    logic [5:0]   v_f  [7];
    logic [W-1:0] v_a  [7];
    logic [W-1:0] v_b  [7];
    logic [W-1:0] v_eh [7];
    logic [W-1:0] v_el [7];
    logic [W-1:0] rh, rl;
    int lat, bcnt;
    v_f  = '{6'b011011, 6'b011010, 6'b011010, 6'b011010, 6'b011010, 6'b011011, 6'b011010};
    v_a  = '{32'd100, 32'hFFFF_FF9C, 32'd5, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF,
             32'hFFFF_FFFB};
    v_b  = '{32'd7, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd10, 32'd0};
    v_eh = '{32'd2, 32'hFFFF_FFFE, 32'd5, 32'd0, 32'd2, 32'd5, 32'hFFFF_FFFB};
    v_el = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFF2,
             32'h1999_9999, 32'hFFFF_FFFF};
    for (int i = 0; i < 7; i++) begin
      do_op(v_f[i], v_a[i], v_b[i], rh, rl, lat, bcnt);
      checks++; if (lat != 34) begin failures++; $display("FAIL div[%0d]_latency got=%0d exp=34", i, lat); end
      checks++; if (rh !== v_eh[i]) begin failures++; $display("FAIL div[%0d]_hi got=%h exp=%h", i, rh, v_eh[i]); end
      checks++; if (rl !== v_el[i]) begin failures++; $display("FAIL div[%0d]_lo got=%h exp=%h", i, rl, v_el[i]); end
    end
  endtask
`else
  task automatic test_nodiv();
    logic [W-1:0] rh, rl;
    int lat, bcnt;
    logic seen_busy, seen_done, seen_stall;
    do_op(6'b011000, 32'd6, 32'd7, rh, rl, lat, bcnt);
    checks++; if (rl !== 32'd42) begin failures++; $display("FAIL nodiv_setup_lo got=%h exp=%h", rl, 32'd42); end
    @(negedge clk);
    aluOp = 2'b10; funct = 6'b011010; opA = 32'd5; opB = 32'd0; start = 1'b1;
    seen_busy = 1'b0; seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (busy) seen_busy = 1'b1;
      if (done) seen_done = 1'b1;
    end
    checks++; if (seen_busy !== 1'b0) begin failures++; $display("FAIL nodiv_busy got=%b exp=0", seen_busy); end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL nodiv_done got=%b exp=0", seen_done); end
    checks++; if (hi !== 32'd0) begin failures++; $display("FAIL nodiv_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd42) begin failures++; $display("FAIL nodiv_lo got=%h exp=%h", lo, 32'd42); end
    // div presented while a mult is running must not stall
    @(negedge clk);
    aluOp = 2'b10; funct = 6'b011001; opA = 32'd2; opB = 32'd3; start = 1'b1;
    @(negedge clk);
    funct = 6'b011011;
    seen_stall = 1'b0; seen_done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (stall) seen_stall = 1'b1;
      if (done) seen_done = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (seen_stall !== 1'b0) begin failures++; $display("FAIL nodiv_stall got=%b exp=0", seen_stall); end
    checks++; if (seen_done !== 1'b1) begin failures++; $display("FAIL nodiv_mult_done got=%b exp=1", seen_done); end
    checks++; if (lo !== 32'd6) begin failures++; $display("FAIL nodiv_mult_lo got=%h exp=%h", lo, 32'd6); end
  endtask
`endif

  task automatic test_reset_abort();
    logic seen_busy, seen_done;
    @(negedge clk);
    aluOp = 2'b10; funct = 6'b011001; opA = 32'hFFFF_FFFF; opB = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (lo === 32'd0) begin failures++; $display("FAIL abort_precond_lo got=%h exp=nonzero", lo); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (hi !== '0) begin failures++; $display("FAIL abort_hi got=%h exp=0", hi); end
    checks++; if (lo !== '0) begin failures++; $display("FAIL abort_lo got=%h exp=0", lo); end
    #1 rst = 1'b0;
    seen_busy = 1'b0; seen_done = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (busy) seen_busy = 1'b1;
      if (done) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin failures++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
    checks++; if (seen_busy !== 1'b0) begin failures++; $display("FAIL abort_no_busy got=%b exp=0", seen_busy); end
    checks++; if (lo !== '0) begin failures++; $display("FAIL abort_lo_after got=%h exp=0", lo); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_stall();
`ifdef ALU_EXEC_DIV_EN
    test_div();
`else
    test_nodiv();
`endif
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
